// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the decode stage: opcodes, ALU encodings and defaults.
// Also holds the operand-usage helpers used by the load-use hazard check.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
               (opcode == OP_S) || (opcode == OP_B) || (opcode == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    endfunction

endpackage

// File: rtl/ALU_decode.sv
// Maps opcode/funct3/funct7[5] to the 4-bit ALU operation used by EX.
module ALU_decode
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_control
);

    alu_op_e alu_op;

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            // Branches compare by subtraction; LUI just passes the immediate through.
            OP_B:    alu_op = ALU_SUB;
            OP_LUI:  alu_op = ALU_PASS_B;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alu_control = alu_op;

endmodule

// File: rtl/id_stage_pipe_regfile.sv
// 2-read/1-write register file with async clear, x0 tie-off and optional WB->ID bypass.
module id_regfile
    import rv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    localparam int         RW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic            we;

    function automatic logic in_range(input logic [4:0] idx);
        return ({1'b0, idx} < NREG);
    endfunction

    // Out-of-range write addresses must not alias onto a low register via truncation.
    assign we = wb_en && (wb_rd != 5'd0) && in_range(wb_rd);

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wb_rd[RW-1:0]] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        if (idx == 5'd0 || !in_range(idx)) begin
            return '0;
        end else if (WB_BYPASS != 0 && we && wb_rd == idx) begin
            return wb_data;
        end else begin
            return regs_q[idx[RW-1:0]];
        end
    endfunction

    assign rs1_data = read_port(rs1_idx);
    assign rs2_data = read_port(rs2_idx);

endmodule

// File: rtl/imm_gen.sv
// Extracts and sign-extends the immediate for every RV32 instruction format.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'd0;
        case (instr[6:0])
            OP_I, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {instr[31:12], 12'd0};
            OP_JAL:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:  imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// RV32 decode stage: decodes the IF instruction, reads operands and loads the ID/EX register,
// inserting a bubble on a load-use hazard and dropping the instruction on flush.
module id_stage_pipe
    import rv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_reg_a,
    output logic [XLEN-1:0] id_reg_b,
    output logic [XLEN-1:0] id_imm,
    output logic [3:0]      id_alu_control,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [6:0]      id_opcode,
    output logic            id_stall
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic [3:0]      alu_control;
    logic            haz;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    id_regfile #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_idx  (rs1),
        .rs2_idx  (rs2),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    ALU_decode u_alu_decode (
        .opcode      (opcode),
        .funct3      (if_instr[14:12]),
        .funct7_5    (if_instr[30]),
        .alu_control (alu_control)
    );

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // Only register fields the instruction actually reads can create a load-use hazard.
    assign haz = if_valid && ex_is_load && (ex_rd != 5'd0) &&
                 ((uses_rs1(opcode) && rs1 == ex_rd) || (uses_rs2(opcode) && rs2 == ex_rd));

    assign id_stall = haz && !flush;
    assign id_ready = ex_ready && !haz;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, reg_a_q, reg_a_d, reg_b_q, reg_b_d, imm_q, imm_d;
    logic [3:0]      alu_q, alu_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [6:0]      opcode_q, opcode_d;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        opcode_d = opcode_q;
        if (ex_ready) begin
            if (flush || haz) begin
                valid_d = 1'b0;
            end else begin
                valid_d  = if_valid;
                pc_d     = if_pc;
                reg_a_d  = rs1_data;
                reg_b_d  = rs2_data;
                imm_d    = imm;
                alu_d    = alu_control;
                rs1_d    = rs1;
                rs2_d    = rs2;
                rd_d     = rd;
                opcode_d = opcode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            opcode_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
        end
    end

    assign id_valid       = valid_q;
    assign id_pc          = pc_q;
    assign id_reg_a       = reg_a_q;
    assign id_reg_b       = reg_b_q;
    assign id_imm         = imm_q;
    assign id_alu_control = alu_q;
    assign id_rs1         = rs1_q;
    assign id_rs2         = rs2_q;
    assign id_rd          = rd_q;
    assign id_opcode      = opcode_q;

endmodule
